// File: rtl/flit_recv_if.sv
// Router-to-node ingress bundle for flit_recv: flit write side, credit return,
// spike lane, config lane and the sticky overflow flag.
interface flit_recv_if #(
  parameter int FW = 59,
  parameter int SW = 24
);
  logic          flit_in_wr;
  logic [FW-1:0] flit_in;
  logic          credit_out;
  logic          spk_in_valid;
  logic [SW-1:0] spk_in_neuid;
  logic          spk_in_ready;
  logic          cfg_in_valid;
  logic [FW-1:0] cfg_in_flit;
  logic          cfg_in_last;
  logic          cfg_in_ready;
  logic          ovf_err;

  // Receiver side (the flit_recv block itself)
  modport slave (
    input  flit_in_wr, flit_in, spk_in_ready, cfg_in_ready,
    output credit_out, spk_in_valid, spk_in_neuid,
           cfg_in_valid, cfg_in_flit, cfg_in_last, ovf_err
  );

  // Environment side (router port plus spike/config consumers)
  modport master (
    output flit_in_wr, flit_in, spk_in_ready, cfg_in_ready,
    input  credit_out, spk_in_valid, spk_in_neuid,
           cfg_in_valid, cfg_in_flit, cfg_in_last, ovf_err
  );
endinterface

// File: rtl/flit_recv.sv
// flit_recv: node ingress stage. Buffers router flits in a 2^B deep FIFO,
// returns one credit per popped flit, and steers each flit by type to the
// spike lane (neuron id) or the config lane (full flit). Unknown types are
// popped, credited and dropped.
// Optional statistics counters are enabled with `define FLIT_RECV_STAT_EN.
module flit_recv #(
  parameter int B   = 4,
  parameter int FW  = 59,
  parameter int FTW = 3,
  parameter int SW  = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  flit_recv_if.slave  bus
`ifdef FLIT_RECV_STAT_EN
  ,
  output logic [15:0] stat_spk_cnt,
  output logic [15:0] stat_drop_cnt
`endif
);

  localparam int DEPTH = 1 << B;

  localparam logic [FTW-1:0] T_SPIKE    = FTW'(3'b000);
  localparam logic [FTW-1:0] T_DATA     = FTW'(3'b001);
  localparam logic [FTW-1:0] T_DATA_END = FTW'(3'b010);
  localparam logic [FTW-1:0] T_WRITE    = FTW'(3'b110);
  localparam logic [FTW-1:0] T_READ     = FTW'(3'b111);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SPK, S_CFG} state_t;

  // FIFO storage and pointers
  logic [FW-1:0] mem [DEPTH];
  logic [FW-1:0] rd_data_q;
  logic [B-1:0]  wr_ptr_q, wr_ptr_d;
  logic [B-1:0]  rd_ptr_q, rd_ptr_d;
  logic [B:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, pop, wr_en, ovf_set;

  // Delivery FSM and hold register
  state_t        state_q, state_d;
  logic [FW-1:0] hold_q, hold_d;
  logic          spk_valid_q, spk_valid_d;
  logic          cfg_valid_q, cfg_valid_d;
  logic          cfg_last_q, cfg_last_d;
  logic          drop_unknown;
  logic [FTW-1:0] load_type;

  assign load_type = rd_data_q[FW-1:FW-FTW];

  // FIFO control: a pop frees a slot in the same cycle, so a write to a full
  // FIFO that coincides with a pop is accepted rather than counted as overflow.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (B+1)'(DEPTH));
    pop      = !empty && ((state_q == S_IDLE) ||
                          (state_q == S_SPK && bus.spk_in_ready) ||
                          (state_q == S_CFG && bus.cfg_in_ready));
    wr_en    = bus.flit_in_wr && (!full || pop);
    ovf_set  = bus.flit_in_wr && full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && pop) begin
      count_d = count_q - 1'b1;
    end
    ovf_d = ovf_q | ovf_set;
  end

  // FIFO pointer, occupancy and sticky overflow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // RAM array with registered read; read-before-write when pointers collide
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= bus.flit_in;
    end
    if (pop) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

  // Next-state and output decode for the pop/load/present sequence
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    spk_valid_d  = spk_valid_q;
    cfg_valid_d  = cfg_valid_q;
    cfg_last_d   = cfg_last_q;
    drop_unknown = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_LOAD;
      end
      S_LOAD: begin
        case (load_type)
          T_SPIKE: begin
            hold_d      = rd_data_q;
            spk_valid_d = 1'b1;
            state_d     = S_SPK;
          end
          T_DATA, T_DATA_END, T_WRITE, T_READ: begin
            hold_d      = rd_data_q;
            cfg_valid_d = 1'b1;
            cfg_last_d  = (load_type != T_DATA);
            state_d     = S_CFG;
          end
          default: begin
            drop_unknown = 1'b1;
            state_d      = S_IDLE;
          end
        endcase
      end
      S_SPK: begin
        if (bus.spk_in_ready) begin
          spk_valid_d = 1'b0;
          state_d     = pop ? S_LOAD : S_IDLE;
        end
      end
      S_CFG: begin
        if (bus.cfg_in_ready) begin
          cfg_valid_d = 1'b0;
          cfg_last_d  = 1'b0;
          state_d     = pop ? S_LOAD : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state with registered lane outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      spk_valid_q <= 1'b0;
      cfg_valid_q <= 1'b0;
      cfg_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      spk_valid_q <= spk_valid_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_last_q  <= cfg_last_d;
    end
  end

  assign bus.credit_out   = pop;
  assign bus.spk_in_valid = spk_valid_q;
  assign bus.spk_in_neuid = hold_q[SW-1:0];
  assign bus.cfg_in_valid = cfg_valid_q;
  assign bus.cfg_in_flit  = hold_q;
  assign bus.cfg_in_last  = cfg_last_q;
  assign bus.ovf_err      = ovf_q;

`ifdef FLIT_RECV_STAT_EN
  logic [15:0] stat_spk_q, stat_spk_d;
  logic [15:0] stat_drop_q, stat_drop_d;

  // Saturating counters; a drop and an overflow in one cycle count once
  always_comb begin
    stat_spk_d  = stat_spk_q;
    stat_drop_d = stat_drop_q;
    if (state_q == S_SPK && bus.spk_in_ready && stat_spk_q != 16'hFFFF) begin
      stat_spk_d = stat_spk_q + 16'd1;
    end
    if ((drop_unknown || ovf_set) && stat_drop_q != 16'hFFFF) begin
      stat_drop_d = stat_drop_q + 16'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_spk_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_spk_q  <= stat_spk_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_spk_cnt  = stat_spk_q;
  assign stat_drop_cnt = stat_drop_q;
`endif

endmodule
